// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the ALU arbiter: ALUOp codes (ctrl_encode_def subset),
// arbiter FSM state codes and owner identifiers.
package alu_arbiter_pkg;

    localparam int ARB_OPW = 5;

    localparam logic [ARB_OPW-1:0] ALUOP_NOP  = 5'd0;
    localparam logic [ARB_OPW-1:0] ALUOP_ADDU = 5'd1;
    localparam logic [ARB_OPW-1:0] ALUOP_SUBU = 5'd2;
    localparam logic [ARB_OPW-1:0] ALUOP_AND  = 5'd3;
    localparam logic [ARB_OPW-1:0] ALUOP_OR   = 5'd4;
    localparam logic [ARB_OPW-1:0] ALUOP_XOR  = 5'd5;

    localparam logic [1:0] ARB_IDLE = 2'b00;
    localparam logic [1:0] ARB_EXEC = 2'b01;
    localparam logic [1:0] ARB_RESP = 2'b10;

    localparam logic ARB_OWNER_0 = 1'b0;
    localparam logic ARB_OWNER_1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// alu_rr_pick: combinational one-hot 2-way grant. Round-robin by default;
// `define ALU_ARB_FIXED_PRIO_EN for fixed priority to port 0.
module alu_rr_pick
    import alu_arbiter_pkg::*;
(
    input  logic       i_req0_valid,
    input  logic       i_req1_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = i_last_grant;

    always_comb begin
        o_grant = 2'b00;
        if (i_req0_valid) begin
            o_grant = 2'b01;
        end else if (i_req1_valid) begin
            o_grant = 2'b10;
        end
    end
`else
    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        o_grant = 2'b00;
        if (i_req0_valid && i_req1_valid) begin
            o_grant = (i_last_grant == ARB_OWNER_0) ? 2'b10 : 2'b01;
        end else if (i_req0_valid) begin
            o_grant = 2'b01;
        end else if (i_req1_valid) begin
            o_grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with an
// IDLE/EXEC/RESP sequence. ALU_ARB_FIXED_PRIO_EN selects fixed priority.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OPW = ARB_OPW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_c,
    input  logic           alu_zero,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp_c,
    output logic           rsp_zero,
    output logic           busy
);

    logic [1:0]     r_state;
    logic           r_owner;
    logic           r_last_grant;
    logic [DW-1:0]  r_alu_a;
    logic [DW-1:0]  r_alu_b;
    logic [OPW-1:0] r_alu_op;
    logic [DW-1:0]  r_rsp_c;
    logic           r_rsp_zero;

    logic [1:0]     w_grant;
    logic           w_idle;
    logic           w_accept;
    logic           w_rsp0_valid;
    logic           w_rsp1_valid;
    logic           w_rsp_hs;

    alu_rr_pick u_pick (
        .i_req0_valid (req0_valid),
        .i_req1_valid (req1_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Ready is masked during reset so no handshake appears to be taken.
    assign w_idle       = (r_state == ARB_IDLE) && !rst;
    assign req0_ready   = w_idle && w_grant[0];
    assign req1_ready   = w_idle && w_grant[1];
    assign w_accept     = req0_ready || req1_ready;

    assign w_rsp0_valid = (r_state == ARB_RESP) && (r_owner == ARB_OWNER_0);
    assign w_rsp1_valid = (r_state == ARB_RESP) && (r_owner == ARB_OWNER_1);
    assign w_rsp_hs     = (w_rsp0_valid && rsp0_ready) || (w_rsp1_valid && rsp1_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_owner      <= ARB_OWNER_0;
            r_last_grant <= ARB_OWNER_1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= ALUOP_NOP;
            r_rsp_c      <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_alu_a      <= w_grant[1] ? req1_a  : req0_a;
                        r_alu_b      <= w_grant[1] ? req1_b  : req0_b;
                        r_alu_op     <= w_grant[1] ? req1_op : req0_op;
                        r_owner      <= w_grant[1];
                        r_last_grant <= w_grant[1];
                        r_state      <= ARB_EXEC;
                    end
                end
                ARB_EXEC: begin
                    r_rsp_c    <= alu_c;
                    r_rsp_zero <= alu_zero;
                    r_state    <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (w_rsp_hs) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_c      = r_rsp_c;
    assign rsp_zero   = r_rsp_zero;
    assign rsp0_valid = w_rsp0_valid;
    assign rsp1_valid = w_rsp1_valid;
    assign busy       = (r_state != ARB_IDLE);

endmodule
